// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage RV32I core.
package pipe_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       data_write_en;
        logic [1:0] wb_sel;
    } ex_mem_ctrl_t;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccBusy  = 2'd1,
        OccFull  = 2'd2
    } occ_e;

    // The skid slot is only ever valid while the main slot is also valid.
    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {skid_v, main_v & ~skid_v};
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline entry: valid + ctrl + data, with load, clear and bubble gating of ctrl.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * XLEN,
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            // Payload is left stale; only valid and ctrl matter for a bubble.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = valid_q ? ctrl_q : '0;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, stall and flush.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * XLEN,
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              in_fire, out_fire;
    logic              main_load, main_clear;
    logic [DATA_W-1:0] main_data_in;
    logic [CTRL_W-1:0] main_ctrl_in;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    pipe_skid_slot #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load_i (main_load),
        .clear_i(main_clear),
        .data_i (main_data_in),
        .ctrl_i (main_ctrl_in),
        .valid_o(out_valid),
        .data_o (out_data),
        .ctrl_o (out_ctrl)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid, skid_load, skid_clear;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_ready_q, in_ready_d;
    occ_e              occ;

    assign occ = occ_e'(occ_count(out_valid, skid_valid));

    always_comb begin
        main_load    = 1'b0;
        main_clear   = flush;
        skid_load    = 1'b0;
        skid_clear   = flush;
        main_data_in = in_data;
        main_ctrl_in = in_ctrl;
        if (!flush) begin
            unique case (occ)
                OccEmpty: main_load = in_fire;
                OccBusy: begin
                    main_load  = in_fire & out_fire;
                    skid_load  = in_fire & ~out_fire;
                    main_clear = out_fire & ~in_fire;
                end
                OccFull: begin
                    if (out_fire) begin
                        main_load    = 1'b1;
                        main_data_in = skid_data;
                        main_ctrl_in = skid_ctrl;
                        skid_clear   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Ready next cycle iff the skid slot will be free.
        in_ready_d = flush | ~(skid_load | (skid_valid & ~skid_clear));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    pipe_skid_slot #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_load),
        .clear_i(skid_clear),
        .data_i (in_data),
        .ctrl_i (in_ctrl),
        .valid_o(skid_valid),
        .data_o (skid_data),
        .ctrl_o (skid_ctrl)
    );

    assign in_ready  = in_ready_q;
    assign occupancy = occ;
`else
    assign in_ready     = ~out_valid | out_ready;
    assign main_load    = in_fire & ~flush;
    assign main_clear   = flush | (out_fire & ~in_fire);
    assign main_data_in = in_data;
    assign main_ctrl_in = in_ctrl;
    assign occupancy    = {1'b0, out_valid};
`endif

endmodule
